// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
// States are plain 2-bit constants so older code comparing raw values keeps working.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_ERR1 = 2'd2;
   localparam state_t ST_ERR2 = 2'd3;

endpackage

// File: rtl/sram_be_array.sv
// Word-wide RAM with per-byte write enables, synchronous write and asynchronous read.
module sram_be_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int NB     = DATA_W / 8
) (
   input  logic              HCLK,
   input  logic              we,
   input  logic [NB-1:0]     be,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge HCLK) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite on-chip RAM target: pipelined address/data phases, sized writes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP
);

   localparam int NB    = DATA_W / 8;
   localparam int LB    = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [2:0] MAX_SIZE = 3'(LB);
   localparam logic [3:0] WAIT_N   = 4'(WAIT_STATES);

   state_t            state_reg, state_next;
   logic              pend_reg, pend_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [LB-1:0]     off_reg, off_next;
   logic              write_reg, write_next;
   logic [2:0]        size_reg, size_next;

   logic              accept, illegal, ready, complete;
   logic [LB-1:0]     align_mask;
   logic [NB-1:0]     lane_be;
   logic [7:0]        lane_lo, lane_hi;
   logic [DATA_W-1:0] mem_rdata;

   assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

   for (genvar gi = 0; gi < LB; gi++) begin : g_align
      assign align_mask[gi] = (3'(gi) < HSIZE);
   end

   assign illegal = (HSIZE > MAX_SIZE)
                 || (|(HADDR[LB-1:0] & align_mask))
                 || (|HADDR[ADDR_W-1:LB+IDX_W]);

   // Only ERR1 and the counting part of WAIT stall the bus.
   assign ready    = !(state_reg == ST_ERR1 || (state_reg == ST_WAIT && cnt_reg != WAIT_N));
   assign complete = pend_reg && (state_reg == ST_IDLE || (state_reg == ST_WAIT && cnt_reg == WAIT_N));

   assign lane_lo = 8'(off_reg);
   assign lane_hi = lane_lo + (8'd1 << size_reg);

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_be[gi] = (8'(gi) >= lane_lo) && (8'(gi) < lane_hi);
   end

   always_comb begin
      state_next = state_reg;
      pend_next  = pend_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      off_next   = off_reg;
      write_next = write_reg;
      size_next  = size_reg;
      if (!ready) begin
         if (state_reg == ST_ERR1) state_next = ST_ERR2;
         else                      cnt_next   = cnt_reg + 4'd1;
      end else begin
         state_next = ST_IDLE;
         pend_next  = 1'b0;
         cnt_next   = 4'd0;
         if (accept) begin
            idx_next   = HADDR[LB+IDX_W-1:LB];
            off_next   = HADDR[LB-1:0];
            write_next = HWRITE;
            size_next  = HSIZE;
            if (illegal) begin
               state_next = ST_ERR1;
            end else begin
               pend_next  = 1'b1;
               state_next = (WAIT_N != 4'd0) ? ST_WAIT : ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_reg <= ST_IDLE;
         pend_reg  <= 1'b0;
         cnt_reg   <= 4'd0;
         idx_reg   <= '0;
         off_reg   <= '0;
         write_reg <= 1'b0;
         size_reg  <= 3'd0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         off_reg   <= off_next;
         write_reg <= write_next;
         size_reg  <= size_next;
      end
   end

   sram_be_array #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH),
      .IDX_W  (IDX_W),
      .NB     (NB)
   ) u_mem (
      .HCLK  (HCLK),
      .we    (complete && write_reg),
      .be    (lane_be),
      .idx   (idx_reg),
      .wdata (HWDATA),
      .rdata (mem_rdata)
   );

   assign HREADYOUT = ready;
   assign HRESP     = (state_reg == ST_ERR1 || state_reg == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = (complete && !write_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait slave and one two-wait slave on shared bus inputs.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        hsel0, hsel2;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] rdata0, rdata2;
   logic        ready0, ready2, resp0, resp2;

   int checks   = 0;
   int failures = 0;

   always #5 HCLK = ~HCLK;

   ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ready0),
      .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
   );

   ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ready2),
      .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // Single non-pipelined transfer; checks the completing data-phase cycle and wait count.
   task automatic xfer(input bit d2, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
      int lows;
      logic rdy;
      lows = 0;
      rdy  = 1'b0;
      hsel0 = !d2; hsel2 = d2;
      HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr; HSIZE = size;
      tick();
      HTRANS = HTRANS_IDLE; hsel0 = 1'b0; hsel2 = 1'b0; HWDATA = wdata;
      for (int c = 0; c < 20; c++) begin
         @(negedge HCLK);
         rdy = d2 ? ready2 : ready0;
         if (rdy) break;
         lows++;
         tick();
      end
      check_eq({tag, "_ready"}, 32'(rdy), 32'd1);
      check_eq({tag, "_resp"}, 32'(d2 ? resp2 : resp0), 32'd0);
      check_eq({tag, "_rdata"}, d2 ? rdata2 : rdata0, wr ? 32'd0 : exp_rd);
      check_eq({tag, "_waits"}, 32'(lows), d2 ? 32'd2 : 32'd0);
      $display("XFER %s dut=%0d %s addr=0x%08h size=%0d wdata=0x%08h rdata=0x%08h waits=%0d",
               tag, d2 ? 2 : 0, wr ? "WR" : "RD", addr, size, wdata, d2 ? rdata2 : rdata0, lows);
      tick();
   endtask

   // Illegal access on the zero-wait slave: expect ERR1 then ERR2, then back to OKAY.
   task automatic err0(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input string tag);
      hsel0 = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr; HSIZE = size;
      tick();
      hsel0 = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wdata;
      @(negedge HCLK);
      check_eq({tag, "_err1_ready"}, 32'(ready0), 32'd0);
      check_eq({tag, "_err1_resp"}, 32'(resp0), 32'd1);
      check_eq({tag, "_err1_rdata"}, rdata0, 32'd0);
      tick();
      @(negedge HCLK);
      check_eq({tag, "_err2_ready"}, 32'(ready0), 32'd1);
      check_eq({tag, "_err2_resp"}, 32'(resp0), 32'd1);
      tick();
      @(negedge HCLK);
      check_eq({tag, "_post_resp"}, 32'(resp0), 32'd0);
      $display("XFER %s dut=0 %s addr=0x%08h size=%0d ERROR", tag, wr ? "WR" : "RD", addr, size);
      tick();
   endtask

   initial begin
      int lows;
      HRESET = 1'b1; hsel0 = 1'b0; hsel2 = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE;
      HWRITE = 1'b0; HSIZE = HSIZE_WORD; HWDATA = '0;
      @(negedge HCLK);
      check_eq("rst_ready0", 32'(ready0), 32'd1);
      check_eq("rst_resp0", 32'(resp0), 32'd0);
      check_eq("rst_rdata0", rdata0, 32'd0);
      check_eq("rst_ready2", 32'(ready2), 32'd1);
      @(negedge HCLK);
      HRESET = 1'b0;
      tick();

      // Back-to-back write then read of the same word, zero waits.
      hsel0 = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
      tick();
      HWDATA = 32'hDEADBEEF; HWRITE = 1'b0;
      @(negedge HCLK);
      check_eq("t1_wr_ready", 32'(ready0), 32'd1);
      check_eq("t1_wr_resp", 32'(resp0), 32'd0);
      check_eq("t1_wr_rdata", rdata0, 32'd0);
      tick();
      HTRANS = HTRANS_IDLE; hsel0 = 1'b0; HWDATA = '0;
      @(negedge HCLK);
      check_eq("t1_rd_ready", 32'(ready0), 32'd1);
      check_eq("t1_rd_rdata", rdata0, 32'hDEADBEEF);
      $display("XFER t1 dut=0 WR+RD addr=0x00000010 rdata=0x%08h", rdata0);
      tick();
      @(negedge HCLK);
      check_eq("t1_idle_rdata", rdata0, 32'd0);

      // Sub-word writes land in their own byte lanes.
      xfer(1'b0, 1'b1, 32'h11, HSIZE_BYTE, 32'h0000AA00, 32'd0, "t2_byte");
      xfer(1'b0, 1'b1, 32'h12, HSIZE_HALF, 32'h55550000, 32'd0, "t2_half");
      xfer(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'd0, 32'h5555AAEF, "t2_read");

      // Two-wait slave, write then read pipelined.
      hsel2 = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
      tick();
      HWDATA = 32'h12345678; HWRITE = 1'b0;
      lows = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge HCLK);
         if (ready2) break;
         check_eq("t3_wait_rdata", rdata2, 32'd0);
         lows++;
         tick();
      end
      check_eq("t3_wr_waits", 32'(lows), 32'd2);
      check_eq("t3_wr_resp", 32'(resp2), 32'd0);
      tick();
      HTRANS = HTRANS_IDLE; hsel2 = 1'b0; HWDATA = '0;
      lows = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge HCLK);
         if (ready2) break;
         lows++;
         tick();
      end
      check_eq("t3_rd_waits", 32'(lows), 32'd2);
      check_eq("t3_rd_rdata", rdata2, 32'h12345678);
      $display("XFER t3 dut=2 WR+RD addr=0x00000020 rdata=0x%08h", rdata2);
      tick();

      // Illegal accesses never disturb memory.
      xfer(1'b0, 1'b1, 32'h00, HSIZE_WORD, 32'hCAFEF00D, 32'd0, "t4_init");
      err0(1'b0, 32'h400, HSIZE_WORD, 32'd0, "t4_range");
      xfer(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'd0, 32'h5555AAEF, "t4_chk10");
      err0(1'b1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF, "t4_unalign");
      err0(1'b0, 32'h08, HSIZE_DWORD, 32'd0, "t4_size");
      xfer(1'b0, 1'b0, 32'h00, HSIZE_WORD, 32'd0, 32'hCAFEF00D, "t4_chk00");

      // Unselected and BUSY cycles are zero-wait OKAY and write nothing.
      hsel0 = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = 32'h00; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
      tick();
      HTRANS = HTRANS_IDLE; HWDATA = 32'h11111111;
      @(negedge HCLK);
      check_eq("t5_nosel_ready", 32'(ready0), 32'd1);
      check_eq("t5_nosel_resp", 32'(resp0), 32'd0);
      check_eq("t5_nosel_rdata", rdata0, 32'd0);
      tick();
      hsel0 = 1'b1; HTRANS = HTRANS_BUSY;
      tick();
      hsel0 = 1'b0; HTRANS = HTRANS_IDLE;
      @(negedge HCLK);
      check_eq("t5_busy_ready", 32'(ready0), 32'd1);
      check_eq("t5_busy_resp", 32'(resp0), 32'd0);
      check_eq("t5_busy_rdata", rdata0, 32'd0);
      $display("XFER t5 dut=0 no-transfer cycles addr=0x00000000");
      tick();
      xfer(1'b0, 1'b0, 32'h00, HSIZE_WORD, 32'd0, 32'hCAFEF00D, "t5_chk00");

      // Reset during a write's wait state abandons the write.
      xfer(1'b1, 1'b1, 32'h30, HSIZE_WORD, 32'hA5A5A5A5, 32'd0, "t6_pre");
      hsel2 = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
      tick();
      hsel2 = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h0BADF00D;
      @(negedge HCLK);
      check_eq("t6_in_wait", 32'(ready2), 32'd0);
      #1 HRESET = 1'b1;
      #1;
      check_eq("t6_rst_ready", 32'(ready2), 32'd1);
      check_eq("t6_rst_resp", 32'(resp2), 32'd0);
      check_eq("t6_rst_rdata", rdata2, 32'd0);
      $display("XFER t6 dut=2 WR addr=0x00000030 aborted by reset");
      @(posedge HCLK);
      @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;
      tick();
      xfer(1'b1, 1'b0, 32'h30, HSIZE_WORD, 32'd0, 32'hA5A5A5A5, "t6_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
